counter_mod_ud: RTL and testbench
=================================

Name: counter_mod_ud

Overview:
- Parametrised successor to the fixed-modulus free-running counter.
- Counts up or down modulo a runtime-programmable modulus, with enable, synchronous load, and start/stop control.
- Runs in free-running or one-shot mode and emits a terminal-count pulse.
- Used as a timebase/event divider in datapath and peripheral control logic.

Parameters:
- WIDTH, 8, counter and modulus width in bits.
- MOD_RST, 200, reset value of the modulus register. Must satisfy 1 <= MOD_RST <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable. Steps only in RUN.
- start  input  1  start/restart pulse.
- stop  input  1  stop request. Returns to IDLE.
- oneshot  input  1  1 = halt at terminal; 0 = wrap and continue. Sampled at each terminal step.
- up_dn  input  1  1 = count up; 0 = count down.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value.
- mod_wr  input  1  write mod_in to the modulus register.
- mod_in  input  WIDTH  new modulus. 0 means 2^WIDTH.
- count_val  output  WIDTH  registered count.
- tc  output  1  terminal-count pulse, combinational.
- busy  output  1  state == RUN.
- done  output  1  state == DONE.

Behaviour:
- Async reset: count_val=0, mod_r=MOD_RST, state=IDLE. All outputs low except count_val=0.
- Effective modulus M = mod_r, or 2^WIDTH when mod_r==0. Legal count range is 0..M-1.
- Terminal condition T:
  - up: count_val >= M-1. The >= covers out-of-range values after a modulus shrink.
  - down: count_val == 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: count holds. start -> RUN; count <= 0 if up_dn=1, else M-1.
  - RUN, en=1, not T: count +/-1.
  - RUN, en=1, T: tc=1 this cycle.
    - oneshot=0: count wraps (up -> 0, down -> M-1); stay in RUN.
    - oneshot=1: count holds its value; next state DONE.
  - RUN, en=0: hold; tc=0.
  - DONE: count holds.
    - start -> RUN with the same initialisation as from IDLE.
    - stop -> IDLE.
- Per-cycle priority: load > stop > start > count step.
  - load in any state: count <= (load_val >= M) ? M-1 : load_val. State unchanged. No step or tc that cycle.
  - stop in any state: -> IDLE, count holds, tc=0.
  - start while in RUN: reinitialise count; stay in RUN; tc=0 that cycle.
- mod_wr: mod_r <= mod_in at the clock edge, in any state, independent of the priority chain.
  - T, start init and load clamping in the same cycle use the old mod_r.
  - New M takes effect from the next cycle.
- Direction change mid-run takes effect immediately; no restart.
- M=1: count is always 0; T is true every enabled RUN cycle.
- All arithmetic is WIDTH-bit with no carry out. M=2^WIDTH up-wraps naturally from 2^WIDTH-1 to 0.

Optional Feature:
- Macro: COUNTER_MOD_UD_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_cnt [15:0].
  - Increments by 1 on every cycle with tc=1; saturates at 16'hFFFF.
  - Cleared by rst and by start.
- Undefined: no wrap_cnt port and no associated logic.

Test Plan:
- Reset mid-count: WIDTH=8, MOD_RST=200, count at 57, rst asserted asynchronously between edges -> count_val=0 and busy=0 immediately, before the next edge.
- Free-running up, M=5: start then en=1 -> sequence 0,1,2,3,4,0,1. tc=1 exactly on the cycles where count_val=4.
- One-shot down, M=4: up_dn=0, oneshot=1, start -> count 3,2,1,0 then holds 0. tc pulses once; done=1 from the next cycle. stop -> IDLE with count held at 0.
- Modulus shrink: count=150 in RUN up with M=200; mod_wr with mod_in=100 -> from the next cycle T is true, tc=1 and count wraps to 0. A following load_val=120 clamps to 99.
- Priority collision: load=1, stop=1, start=1, en=1 in the same RUN cycle with load_val=7 -> count=7, state unchanged (RUN), tc=0. Next cycle, stop alone -> IDLE.
- Edge moduli:
  - mod_in=0 with WIDTH=8: up count 254, 255, 0; tc at 255.
  - mod_in=1: count stays 0 with tc high every enabled cycle.
  - With COUNTER_MOD_UD_WRAP_CNT_EN: wrap_cnt increments per tc and is cleared by start.

Source files
------------

// File: rtl/counter_mod_ud.sv
// counter_mod_ud: up/down counter modulo a runtime-programmable modulus.
// Supports enable, synchronous load, start/stop control, free-running or
// one-shot operation and a combinational terminal-count pulse.
// Optional: define COUNTER_MOD_UD_WRAP_CNT_EN to add a saturating 16-bit
// wrap_cnt output that counts tc pulses and is cleared by start.
module counter_mod_ud #(
   parameter int WIDTH   = 8,
   parameter int MOD_RST = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_in,
   output logic [WIDTH-1:0] count_val,
   output logic             tc,
`ifdef COUNTER_MOD_UD_WRAP_CNT_EN
   output logic [15:0]      wrap_cnt,
`endif
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mod_r;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] top;      // M-1; mod_r==0 (M=2^WIDTH) wraps to all ones
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] clamp_val;
   logic             term;
   logic             step;

   assign top       = mod_r - 1'b1;
   // Up uses >= so a count left above the range by a modulus shrink still terminates
   assign term      = up_dn ? (count_val >= top) : (count_val == '0);
   assign init_val  = up_dn ? '0 : top;
   // load_val >= M is the same as load_val > M-1, and never true when M=2^WIDTH
   assign clamp_val = (load_val > top) ? top : load_val;
   // A step happens only when no higher-priority control claims the cycle
   assign step      = (state == RUN) && en && !load && !stop && !start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: load > stop > start > step
   always_comb begin
      state_nxt = state;
      if (load)                          state_nxt = state;
      else if (stop)                     state_nxt = IDLE;
      else if (start)                    state_nxt = RUN;
      else if (step && term && oneshot)  state_nxt = DONE;
   end

   // Outputs decoded from state and the terminal step
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
      tc   = step && term;
   end

   // Next count value, same priority chain as the state
   always_comb begin
      count_nxt = count_val;
      if (load)
         count_nxt = clamp_val;
      else if (stop)
         count_nxt = count_val;
      else if (start)
         count_nxt = init_val;
      else if (step) begin
         if (term)
            count_nxt = oneshot ? count_val : init_val;
         else
            count_nxt = up_dn ? count_val + 1'b1 : count_val - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_val <= '0;
      else     count_val <= count_nxt;
   end

   // Modulus register, written independently of the control chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         mod_r <= WIDTH'(MOD_RST);
      else if (mod_wr) mod_r <= mod_in;
   end

`ifdef COUNTER_MOD_UD_WRAP_CNT_EN
   // Saturating count of terminal pulses, cleared whenever start is seen
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         wrap_cnt <= '0;
      else if (start)                  wrap_cnt <= '0;
      else if (tc && wrap_cnt != '1)   wrap_cnt <= wrap_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_counter_mod_ud.sv
// Scoreboard bench for counter_mod_ud (WIDTH=8, MOD_RST=200). An integer
// reference model predicts each cycle's outputs, which are queued when the
// inputs are driven and popped/compared against the DUT before the edge.
module tb_counter_mod_ud;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 0, start = 0, stop = 0, oneshot = 0, up_dn = 1;
   logic         load = 0, mod_wr = 0;
   logic [W-1:0] load_val = '0, mod_in = '0;
   logic [W-1:0] count_val;
   logic         tc, busy, done;
`ifdef COUNTER_MOD_UD_WRAP_CNT_EN
   logic [15:0]  wrap_cnt;
`endif

   counter_mod_ud #(.WIDTH(W), .MOD_RST(200)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
      .oneshot(oneshot), .up_dn(up_dn), .load(load), .load_val(load_val),
      .mod_wr(mod_wr), .mod_in(mod_in), .count_val(count_val), .tc(tc),
`ifdef COUNTER_MOD_UD_WRAP_CNT_EN
      .wrap_cnt(wrap_cnt),
`endif
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int cnt; bit tc; bit busy; bit done; int wc;
   } exp_t;
   exp_t sb[$];

   // Reference model state: 0=IDLE 1=RUN 2=DONE
   int m_st = 0, m_cnt = 0, m_mod = 200, m_wc = 0;

   function automatic int eff_m();
      return (m_mod == 0) ? 256 : m_mod;
   endfunction

   function automatic bit m_term();
      return up_dn ? (m_cnt >= eff_m() - 1) : (m_cnt == 0);
   endfunction

   function automatic bit m_tc();
      return (m_st == 1) && en && !load && !stop && !start && m_term();
   endfunction

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_mod = 200; m_wc = 0;
   endtask

   task automatic model_step();
      int M; bit t, tcv;
      M = eff_m(); t = m_term(); tcv = m_tc();
      if (start) m_wc = 0;
      else if (tcv && m_wc < 65535) m_wc++;
      if (load) m_cnt = (int'(load_val) >= M) ? M - 1 : int'(load_val);
      else if (stop) m_st = 0;
      else if (start) begin m_st = 1; m_cnt = up_dn ? 0 : M - 1; end
      else if (m_st == 1 && en) begin
         if (t) begin
            if (oneshot) m_st = 2;
            else m_cnt = up_dn ? 0 : M - 1;
         end else m_cnt = up_dn ? (m_cnt + 1) % 256 : m_cnt - 1;
      end
      if (mod_wr) m_mod = int'(mod_in);
   endtask

   // One clock: inputs already driven; predict, compare at negedge+1, then advance
   task automatic cyc(input string tag);
      exp_t e;
      @(negedge clk); #1;
      sb.push_back('{m_cnt, m_tc(), m_st == 1, m_st == 2, m_wc});
      e = sb.pop_front();
      chk({tag, ".cnt"},  32'(count_val), 32'(e.cnt));
      chk({tag, ".tc"},   32'(tc),        32'(e.tc));
      chk({tag, ".busy"}, 32'(busy),      32'(e.busy));
      chk({tag, ".done"}, 32'(done),      32'(e.done));
`ifdef COUNTER_MOD_UD_WRAP_CNT_EN
      chk({tag, ".wc"},   32'(wrap_cnt),  32'(e.wc));
`endif
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_in();
      en = 0; start = 0; stop = 0; load = 0; mod_wr = 0;
   endtask

   task automatic set_mod(input logic [W-1:0] v);
      idle_in(); mod_wr = 1; mod_in = v; cyc("modwr"); mod_wr = 0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst.cnt", 32'(count_val), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.tc", 32'(tc), 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      // Count to 57 with M=200, then async reset between edges
      up_dn = 1; oneshot = 0; start = 1; en = 1; cyc("go57");
      start = 0;
      repeat (57) cyc("up57");
      chk("pre_rst.cnt", 32'(count_val), 57);
      #2 rst = 1; #1;
      chk("async_rst.cnt", 32'(count_val), 0);
      chk("async_rst.busy", 32'(busy), 0);
      model_reset(); idle_in();
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      // Free-running up, M=5
      set_mod(5);
      up_dn = 1; oneshot = 0; start = 1; cyc("fr_start");
      start = 0; en = 1;
      repeat (8) cyc("fr_up");

      // One-shot down, M=4, then stop
      set_mod(4);
      up_dn = 0; oneshot = 1; start = 1; cyc("os_start");
      start = 0; en = 1;
      repeat (6) cyc("os_dn");
      en = 0; stop = 1; cyc("os_stop");
      stop = 0;
      repeat (2) cyc("os_idle");
      chk("os_held", 32'(count_val), 0);

      // Modulus shrink while counting up past the new range
      set_mod(200);
      up_dn = 1; oneshot = 0; start = 1; cyc("sh_start");
      start = 0; en = 1;
      repeat (150) cyc("sh_up");
      mod_wr = 1; mod_in = 100; cyc("sh_wr");
      mod_wr = 0;
      repeat (3) cyc("sh_wrap");
      load = 1; load_val = 120; cyc("sh_load");
      load = 0; en = 0; cyc("sh_clamp");
      chk("clamp99", 32'(count_val), 99);

      // Priority collision in RUN
      en = 1; load = 1; stop = 1; start = 1; load_val = 7; cyc("pri_all");
      load = 0; start = 0; en = 0; stop = 1; cyc("pri_stop");
      stop = 0; cyc("pri_idle");

      // M = 2^WIDTH
      set_mod(0);
      up_dn = 1; start = 1; cyc("m0_start");
      start = 0; load = 1; load_val = 254; cyc("m0_load");
      load = 0; en = 1;
      repeat (4) cyc("m0_up");

      // M = 1
      set_mod(1);
      start = 1; cyc("m1_start");
      start = 0; en = 1;
      repeat (3) cyc("m1_run");
      up_dn = 0; repeat (2) cyc("m1_dn");

      // Randomised control mix
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(0, 9) < 8);
         start   = ($urandom_range(0, 29) == 0);
         stop    = ($urandom_range(0, 49) == 0);
         load    = ($urandom_range(0, 29) == 0);
         mod_wr  = ($urandom_range(0, 39) == 0);
         oneshot = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
         load_val = W'($urandom);
         mod_in   = W'($urandom_range(0, 12));
         cyc("rand");
      end

      if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
